// File: rtl/rr_mux_nto1.sv
// Registered N-to-1 valid/ready multiplexer with external-select or round-robin arbitration.
// Optional RRMUX_STATS_EN adds a 16-bit count of completed output handshakes (xfer_cnt).
module rr_mux_nto1 #(
   parameter  int WIDTH = 8,
   parameter  int N     = 4,
   localparam int SELW  = $clog2(N)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [N*WIDTH-1:0]   in_data,
   input  logic [N-1:0]         in_valid,
   output logic [N-1:0]         in_ready,
   input  logic                 mode,
   input  logic [SELW-1:0]      sel,
`ifdef RRMUX_STATS_EN
   output logic [15:0]          xfer_cnt,
`endif
   output logic [WIDTH-1:0]     out_data,
   output logic [SELW-1:0]      out_ch,
   output logic                 out_valid,
   input  logic                 out_ready
);

   logic [SELW-1:0]  last;
   logic [N-1:0]     grant;
   logic [SELW-1:0]  gidx;
   logic [WIDTH-1:0] gdata;
   logic             can_load;
   logic             xfer;
   logic             found;

   assign can_load = !out_valid || out_ready;

   // Round-robin search is split in two passes (above last, then wrap) so every index stays constant.
   always_comb begin
      grant = '0;
      found = 1'b0;
      if (!mode) begin
         for (int i = 0; i < N; i++) begin
            if (int'(sel) == i) grant[i] = in_valid[i];
         end
      end else begin
         for (int i = 0; i < N; i++) begin
            if (!found && in_valid[i] && (i > int'(last))) begin
               grant[i] = 1'b1;
               found    = 1'b1;
            end
         end
         for (int i = 0; i < N; i++) begin
            if (!found && in_valid[i] && (i <= int'(last))) begin
               grant[i] = 1'b1;
               found    = 1'b1;
            end
         end
      end
   end

   always_comb begin
      gidx  = '0;
      gdata = '0;
      for (int i = 0; i < N; i++) begin
         if (grant[i]) begin
            gidx  = SELW'(i);
            gdata = in_data[i*WIDTH +: WIDTH];
         end
      end
   end

   assign in_ready = (can_load && !rst) ? grant : '0;
   assign xfer     = |in_ready;

   // Output register stage: reload on transfer, otherwise drain on consumer handshake.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_ch    <= '0;
         last      <= SELW'(N-1);
      end else if (xfer) begin
         out_valid <= 1'b1;
         out_data  <= gdata;
         out_ch    <= gidx;
         if (mode) last <= gidx;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

`ifdef RRMUX_STATS_EN
   always_ff @(posedge clk) begin
      if (rst)                        xfer_cnt <= '0;
      else if (out_valid && out_ready) xfer_cnt <= xfer_cnt + 16'd1;
   end
`endif

endmodule

// File: tb/tb_rr_mux_nto1.sv
// Scoreboard bench for rr_mux_nto1 (WIDTH=8, N=4): directed scenarios followed by random traffic.
module tb_rr_mux_nto1;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] in_data;
   logic [3:0]  in_valid;
   logic [3:0]  in_ready;
   logic        mode;
   logic [1:0]  sel;
   logic [7:0]  out_data;
   logic [1:0]  out_ch;
   logic        out_valid;
   logic        out_ready;
`ifdef RRMUX_STATS_EN
   logic [15:0] xfer_cnt;
`endif

   int n_checks = 0;
   int n_errors = 0;

   // model state
   int         m_last;
   bit         m_ovalid;
   int         m_hs;
   logic [9:0] sbq[$];

   always #5 clk = ~clk;

   rr_mux_nto1 #(.WIDTH(8), .N(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .mode      (mode),
      .sel       (sel),
`ifdef RRMUX_STATS_EN
      .xfer_cnt  (xfer_cnt),
`endif
      .out_data  (out_data),
      .out_ch    (out_ch),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
      end
   endtask

   function automatic int mgrant(input bit md, input int s, input logic [3:0] v, input int lst);
      if (!md) return v[s] ? s : -1;
      for (int k = 1; k <= 4; k++) begin
         int i;
         i = (lst + k) % 4;
         if (v[i]) return i;
      end
      return -1;
   endfunction

   // One clock cycle: drive at negedge, check comb/output state, advance model, wait for next negedge.
   task automatic step(input bit md, input int s, input logic [3:0] v, input bit rdy);
      int         g;
      bit         cl;
      logic [3:0] er;
      logic [9:0] front;
      mode = md; sel = s[1:0]; in_valid = v; out_ready = rdy;
      #1;
      g  = mgrant(md, s, v, m_last);
      cl = !m_ovalid || rdy;
      er = (cl && g >= 0) ? 4'(1 << g) : 4'b0000;
      chk_eq("in_ready", in_ready, er);
      chk_eq("out_valid", out_valid, m_ovalid);
      if (m_ovalid) begin
         if (sbq.size() == 0) begin
            chk_eq("sb_depth", sbq.size(), 1);
         end else begin
            front = sbq[0];
            chk_eq("out_ch", out_ch, front[9:8]);
            chk_eq("out_data", out_data, front[7:0]);
            if (rdy) begin
               void'(sbq.pop_front());
               m_hs++;
            end
         end
      end
      if (cl && g >= 0) begin
         sbq.push_back({2'(g), in_data[g*8 +: 8]});
         m_ovalid = 1'b1;
         if (md) m_last = g;
      end else if (rdy) begin
         m_ovalid = 1'b0;
      end
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1; in_valid = 4'b1111; mode = 1'b1; out_ready = 1'b1; sel = 2'd0;
      repeat (2) begin
         #1;
         chk_eq("rst_in_ready", in_ready, 4'b0000);
         @(negedge clk);
      end
      rst = 1'b0; in_valid = 4'b0000;
      m_last = 3; m_ovalid = 1'b0; m_hs = 0;
      sbq.delete();
      #1;
      chk_eq("rst_out_valid", out_valid, 0);
      chk_eq("rst_out_data", out_data, 0);
      chk_eq("rst_out_ch", out_ch, 0);
`ifdef RRMUX_STATS_EN
      chk_eq("rst_xfer_cnt", xfer_cnt, 0);
`endif
   endtask

   initial begin
      rst = 1'b0; in_valid = '0; mode = 1'b0; sel = '0; out_ready = 1'b0;
      in_data = {8'h40, 8'h30, 8'h20, 8'h10};
      m_last = 3; m_ovalid = 1'b0; m_hs = 0;
      @(negedge clk);

      // reset and external select
      do_reset();
      step(1'b0, 2, 4'b1111, 1'b1);
      chk_eq("t2_data_sel2", out_data, 8'h30);
      chk_eq("t2_ch_sel2", out_ch, 2);
      step(1'b0, 3, 4'b1111, 1'b1);
      chk_eq("t2_data_sel3", out_data, 8'h40);
      chk_eq("t2_ch_sel3", out_ch, 3);

      // round-robin rotation from reset
      do_reset();
      for (int i = 0; i < 8; i++) begin
         step(1'b1, 0, 4'b1111, 1'b1);
         chk_eq("t3_rr_ch", out_ch, i % 4);
      end

      // sparse valid: alternate 1,3
      for (int i = 0; i < 4; i++) begin
         step(1'b1, 0, 4'b1010, 1'b1);
         chk_eq("t4_rr_ch", out_ch, (i % 2 == 0) ? 1 : 3);
      end

      // backpressure
      step(1'b1, 0, 4'b0010, 1'b1);
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 0, 4'b1111, 1'b0);
         chk_eq("t5_hold_data", out_data, 8'h20);
      end
      step(1'b1, 0, 4'b1111, 1'b1);
      chk_eq("t5_reload_ch", out_ch, 2);

      // mode switch preserves the round-robin pointer
      step(1'b1, 0, 4'b0011, 1'b1);
      step(1'b1, 0, 4'b0010, 1'b1);
      step(1'b0, 0, 4'b1111, 1'b1);
      step(1'b0, 0, 4'b1111, 1'b1);
      step(1'b1, 0, 4'b1111, 1'b1);
      chk_eq("t6_resume_ch", out_ch, 2);
      step(1'b1, 0, 4'b0000, 1'b1);
`ifdef RRMUX_STATS_EN
      #1;
      chk_eq("t6_xfer_cnt", xfer_cnt, m_hs);
      @(negedge clk);
`endif

      // random traffic with a mid-stream reset
      for (int c = 0; c < 300; c++) begin
         if (c == 150) do_reset();
         in_data = $urandom;
         step(1'($urandom_range(0, 1)), $urandom_range(0, 3), 4'($urandom), $urandom_range(0, 3) != 0);
      end
      for (int c = 0; c < 3; c++) step(1'b1, 0, 4'b0000, 1'b1);
      chk_eq("final_sb_depth", sbq.size(), 0);
`ifdef RRMUX_STATS_EN
      #1;
      chk_eq("final_xfer_cnt", xfer_cnt, m_hs);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
